// File: rtl/instruction_decode_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU classes and the
// control bundle carried down the pipeline into execute and memory.
package instruction_decode_pkg;

  localparam int PC_WIDTH       = 11;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = CTRL_NOP;
    case (opcode)
      OP_RTYPE: c = '{reg_dst: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1,
                      mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, alu_op: ALU_FUNCT};
      OP_LW:    c = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1,
                      mem_read: 1'b1, mem_write: 1'b0, branch: 1'b0, alu_op: ALU_ADD};
      OP_SW:    c = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b0,
                      mem_read: 1'b0, mem_write: 1'b1, branch: 1'b0, alu_op: ALU_ADD};
      OP_BEQ:   c = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
                      mem_read: 1'b0, mem_write: 1'b0, branch: 1'b1, alu_op: ALU_SUB};
      OP_ADDI:  c = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b1,
                      mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, alu_op: ALU_ADD};
      default:  c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two async read ports, one sync write port, r0 tied
// to zero, and a same-cycle write-through bypass from writeback.
module register_file
  import instruction_decode_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1_i,
  input  logic [REG_ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0]     rdata1_o,
  output logic [DATA_WIDTH-1:0]     rdata2_o,
  input  logic                      we_i,
  input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i
);

  logic [DATA_WIDTH-1:0] regs_q [32];
  logic                  wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Bypass lets a value written this cycle be consumed by the instruction in ID.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (wr_en && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (wr_en && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes the IF/ID instruction, reads registers, detects load-use
// hazards and owns the ID/EX pipeline register.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     instruccion,
  input  logic [PC_WIDTH-1:0]       pc,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
  input  logic [DATA_WIDTH-1:0]     wb_write_data,
  input  logic                      flush,
  output logic                      stall,
  output logic [PC_WIDTH-1:0]       id_ex_pc,
  output logic [DATA_WIDTH-1:0]     id_ex_read_data_1,
  output logic [DATA_WIDTH-1:0]     id_ex_read_data_2,
  output logic [DATA_WIDTH-1:0]     id_ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
  output logic                      id_ex_reg_dst,
  output logic                      id_ex_alu_src,
  output logic                      id_ex_mem_to_reg,
  output logic                      id_ex_reg_write,
  output logic                      id_ex_mem_read,
  output logic                      id_ex_mem_write,
  output logic                      id_ex_branch,
  output logic [1:0]                id_ex_alu_op
);

  logic [5:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic [DATA_WIDTH-1:0]     rdata1, rdata2, imm;
  logic                      uses_rt, rs_hit, rt_hit;
  ctrl_t                     ctrl;

  assign opcode = instruccion[31:26];
  assign rs     = instruccion[25:21];
  assign rt     = instruccion[20:16];
  assign rd     = instruccion[15:11];
  assign imm    = {{16{instruccion[15]}}, instruccion[15:0]};
  assign ctrl   = decode_ctrl(opcode);

  register_file u_regfile (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     (wb_reg_write),
    .waddr_i  (wb_write_reg),
    .wdata_i  (wb_write_data)
  );

  logic [PC_WIDTH-1:0]       pc_q,  pc_d;
  logic [DATA_WIDTH-1:0]     rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q,  rs_d,  rt_q,  rt_d,  rd_q,  rd_d;
  ctrl_t                     ctrl_q, ctrl_d;

  // A flush overrides the hazard so fetch is free to take the branch target.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign rs_hit  = (rt_q == rs);
  assign rt_hit  = uses_rt && (rt_q == rt);
  assign stall   = ctrl_q.mem_read && (rt_q != '0) && (rs_hit || rt_hit) && !flush;

  always_comb begin
    pc_d   = '0;
    rd1_d  = '0;
    rd2_d  = '0;
    imm_d  = '0;
    rs_d   = '0;
    rt_d   = '0;
    rd_d   = '0;
    ctrl_d = CTRL_NOP;
    if (!flush && !stall) begin
      pc_d   = pc;
      rd1_d  = rdata1;
      rd2_d  = rdata2;
      imm_d  = imm;
      rs_d   = rs;
      rt_d   = rt;
      rd_d   = rd;
      ctrl_d = ctrl;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= CTRL_NOP;
    end else begin
      pc_q   <= pc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign id_ex_pc          = pc_q;
  assign id_ex_read_data_1 = rd1_q;
  assign id_ex_read_data_2 = rd2_q;
  assign id_ex_imm         = imm_q;
  assign id_ex_rs          = rs_q;
  assign id_ex_rt          = rt_q;
  assign id_ex_rd          = rd_q;
  assign id_ex_reg_dst     = ctrl_q.reg_dst;
  assign id_ex_alu_src     = ctrl_q.alu_src;
  assign id_ex_mem_to_reg  = ctrl_q.mem_to_reg;
  assign id_ex_reg_write   = ctrl_q.reg_write;
  assign id_ex_mem_read    = ctrl_q.mem_read;
  assign id_ex_mem_write   = ctrl_q.mem_write;
  assign id_ex_branch      = ctrl_q.branch;
  assign id_ex_alu_op      = ctrl_q.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode, register file, bypass,
// load-use stall, flush priority and asynchronous reset.
module tb_instruction_decode;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruccion;
  logic [10:0] pc;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic        stall;
  logic [10:0] id_ex_pc;
  logic [31:0] id_ex_read_data_1, id_ex_read_data_2, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_reg_dst, id_ex_alu_src, id_ex_mem_to_reg, id_ex_reg_write;
  logic        id_ex_mem_read, id_ex_mem_write, id_ex_branch;
  logic [1:0]  id_ex_alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  instruction_decode dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .instruccion       (instruccion),
    .pc                (pc),
    .wb_reg_write      (wb_reg_write),
    .wb_write_reg      (wb_write_reg),
    .wb_write_data     (wb_write_data),
    .flush             (flush),
    .stall             (stall),
    .id_ex_pc          (id_ex_pc),
    .id_ex_read_data_1 (id_ex_read_data_1),
    .id_ex_read_data_2 (id_ex_read_data_2),
    .id_ex_imm         (id_ex_imm),
    .id_ex_rs          (id_ex_rs),
    .id_ex_rt          (id_ex_rt),
    .id_ex_rd          (id_ex_rd),
    .id_ex_reg_dst     (id_ex_reg_dst),
    .id_ex_alu_src     (id_ex_alu_src),
    .id_ex_mem_to_reg  (id_ex_mem_to_reg),
    .id_ex_reg_write   (id_ex_reg_write),
    .id_ex_mem_read    (id_ex_mem_read),
    .id_ex_mem_write   (id_ex_mem_write),
    .id_ex_branch      (id_ex_branch),
    .id_ex_alu_op      (id_ex_alu_op)
  );

  // Control bundle in reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op order
  logic [8:0] ctl;
  assign ctl = {id_ex_reg_dst, id_ex_alu_src, id_ex_mem_to_reg, id_ex_reg_write,
                id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_alu_op};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_reg_write  = en;
    wb_write_reg  = r;
    wb_write_data = d;
  endtask

  initial begin
    reset_n     = 1'b1;
    instruccion = 32'hFC00_0000;
    pc          = 11'd0;
    flush       = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_ctl", {23'd0, ctl}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    tick();
    tick();
    #2 reset_n = 1'b1;

    // Fill r3 and r4 via writeback
    tick();
    wb(1'b1, 5'd3, 32'h0000_00AA);
    tick();
    wb(1'b1, 5'd4, 32'h0000_0011);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    instruccion = 32'h0064_2820;  // add r5,r3,r4
    pc          = 11'h004;
    tick();
    chk("add_rd1", id_ex_read_data_1, 32'h0000_00AA);
    chk("add_rd2", id_ex_read_data_2, 32'h0000_0011);
    chk("add_rd", {27'd0, id_ex_rd}, 32'd5);
    chk("add_ctl", {23'd0, ctl}, {23'd0, 9'b1_0_0_1_0_0_0_10});
    chk("add_pc", {21'd0, id_ex_pc}, 32'h004);

    // Bypass: write r7 while decoding add r8,r7,r7
    wb(1'b1, 5'd7, 32'h1234_5678);
    instruccion = 32'h00E7_4020;
    tick();
    chk("byp_rd1", id_ex_read_data_1, 32'h1234_5678);
    chk("byp_rd2", id_ex_read_data_2, 32'h1234_5678);

    // Write to r0 is ignored even with the bypass path active
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    instruccion = 32'h0000_4820;  // add r9,r0,r0
    tick();
    chk("r0_byp", id_ex_read_data_1, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk("r0_rd", id_ex_read_data_2, 32'd0);

    // addi r1,r0,-4
    instruccion = 32'h2001_FFFC;
    tick();
    chk("addi_imm", id_ex_imm, 32'hFFFF_FFFC);
    chk("addi_ctl", {23'd0, ctl}, {23'd0, 9'b0_1_0_1_0_0_0_00});
    chk("addi_rt", {27'd0, id_ex_rt}, 32'd1);

    // sw r2,4(r1) and beq r1,r2,3
    instruccion = 32'hAC22_0004;
    tick();
    chk("sw_ctl", {23'd0, ctl}, {23'd0, 9'b0_1_0_0_0_1_0_00});
    instruccion = 32'h1022_0003;
    tick();
    chk("beq_ctl", {23'd0, ctl}, {23'd0, 9'b0_0_0_0_0_0_1_01});

    // Unknown opcode 0x3F
    instruccion = 32'hFFFF_FFFF;
    tick();
    chk("unk_ctl", {23'd0, ctl}, 32'd0);
    chk("unk_rs", {27'd0, id_ex_rs}, 32'd31);

    // Load-use: lw r2,0(r1) then add r3,r2,r2
    instruccion = 32'h8C22_0000;
    tick();
    chk("lw_ctl", {23'd0, ctl}, {23'd0, 9'b0_1_1_1_1_0_0_00});
    instruccion = 32'h0042_1820;
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble_ctl", {23'd0, ctl}, 32'd0);
    chk("lu_bubble_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("lu_stall_clr", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_add_rs", {27'd0, id_ex_rs}, 32'd2);
    chk("lu_add_rt", {27'd0, id_ex_rt}, 32'd2);
    chk("lu_add_ctl", {23'd0, ctl}, {23'd0, 9'b1_0_0_1_0_0_0_10});

    // addi r2,r1,1 after a load of r2: rt is a destination, no hazard
    instruccion = 32'h8C22_0000;
    tick();
    instruccion = 32'h2022_0001;
    #1;
    chk("addi_nostall", {31'd0, stall}, 32'd0);
    tick();

    // Flush overrides the load-use stall
    instruccion = 32'h8C22_0000;
    tick();
    instruccion = 32'h0042_1820;
    flush       = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_bubble_ctl", {23'd0, ctl}, 32'd0);
    chk("fl_bubble_rd", {27'd0, id_ex_rd}, 32'd0);

    // Mid-stream asynchronous reset clears ID/EX and the register file
    instruccion = 32'h0064_2820;
    tick();
    chk("pre_rst_ctl", {23'd0, ctl}, {23'd0, 9'b1_0_0_1_0_0_0_10});
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {23'd0, ctl}, 32'd0);
    chk("mid_rst_rd1", id_ex_read_data_1, 32'd0);
    chk("mid_rst_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    #2 reset_n = 1'b1;
    instruccion = 32'h00A3_3020;  // add r6,r5,r3
    tick();
    chk("post_rst_r5", id_ex_read_data_1, 32'd0);
    chk("post_rst_r3", id_ex_read_data_2, 32'd0);
    chk("post_rst_rd", {27'd0, id_ex_rd}, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the 32-bit MIPS-subset processor, directly downstream of the fetch stage's IF/ID register. It decodes the held instruction and reads the 32-entry register file, which the writeback stage updates through this block. It detects load-use hazards, stalling fetch, and applies flushes from branch resolution. It owns the ID/EX pipeline register, so every result reaches the execute stage one cycle after the instruction is presented.

## Interface
- PC_WIDTH, 11, instruction-memory address width; matches fetch PC
- DATA_WIDTH, 32, instruction and register width
- REG_ADDR_WIDTH, 5, register index width (32 registers)

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instruccion  in  32  instruction from IF/ID
- pc  in  11  incremented PC from IF/ID
- wb_reg_write  in  1  writeback write enable
- wb_write_reg  in  5  writeback destination register
- wb_write_data  in  32  writeback data
- flush  in  1  branch taken in EX; squash instruction in ID
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- id_ex_pc  out  11  registered PC
- id_ex_read_data_1 / id_ex_read_data_2  out  32 each  registered rs/rt values
- id_ex_imm  out  32  registered sign-extended instr[15:0]
- id_ex_rs / id_ex_rt / id_ex_rd  out  5 each  registered register fields
- id_ex_reg_dst, id_ex_alu_src, id_ex_mem_to_reg, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch  out  1 each  registered control
- id_ex_alu_op  out  2  registered ALU class

## Operation
- Opcode decode (instr[31:26]) sets the control signals, listed as reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op:
  - 0x00 R-type: 1,0,0,1,0,0,0,2'b10
  - 0x23 lw: 0,1,1,1,1,0,0,2'b00
  - 0x2B sw: x,1,x,0,0,1,0,2'b00, with don't-cares driven 0
  - 0x04 beq: 0,0,0,0,0,0,1,2'b01
  - 0x08 addi: 0,1,0,1,0,0,0,2'b00
  - any other opcode: all control 0 (nop)
- Register file:
  - 32x32, written on the rising clock edge when wb_reg_write=1 and wb_write_reg≠0.
  - Register 0 always reads 0.
  - Write-through bypass: if a read index equals wb_write_reg, wb_reg_write=1 and the index ≠0, the read returns wb_write_data in the same cycle.
- Sign extension: id_ex_imm = {16{instr[15]}, instr[15:0]}.
- Load-use hazard:
  - uses_rt is true for R-type, sw and beq.
  - stall = id_ex_mem_read & (id_ex_rt≠0) & (id_ex_rt==rs | (uses_rt & id_ex_rt==rt)) & ~flush.
- ID/EX update each rising edge, by priority:
  - flush=1: load a bubble (all control 0, data fields 0).
  - else stall=1: load a bubble; the instruction stays in IF/ID and re-decodes next cycle.
  - else: load the decoded instruction.
- Every bubble is a true nop: id_ex_reg_write=0 and id_ex_mem_write=0.

## Timing
- Latency: one cycle from the IF/ID outputs to the id_ex_* outputs.
- stall and the register-read path are combinational within the cycle. stall must settle before the fetch PC and IF/ID write enables sample.
- reset_n low: all id_ex_* outputs and all registers clear to 0 immediately, regardless of clock. stall reads 0 while in reset, because id_ex_mem_read=0.
- Reset release is synchronised by the integrator. The first edge after release latches normally.
- A load followed directly by a dependent instruction gives exactly one stall cycle. The second decode of the dependent instruction sees the bubble in ID/EX and proceeds.
- Writeback to a register and a read of that register in the same cycle: the read returns the new value.
- flush and stall asserting together: flush wins, and stall is forced 0 so fetch takes the branch target.

## Structure
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - ALU_OP encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_FUNCT=2'b10
  - control-bundle field definitions, reused by execute and memory stages
- One sub-module, register_file: 2 async read ports, 1 sync write port, reg-0 hardwiring, write-through bypass, async active-low clear.
- Decode logic, hazard logic and the ID/EX register stay in instruction_decode.

## Test plan
- Reset: hold reset_n=0 mid-stream → all id_ex_* = 0 immediately, stall=0; after release, reading r5 returns 0.
- Writeback then R-type: write r3=0x0000_00AA and r4=0x0000_0011, then instr add r5,r3,r4 (0x00642820) → next cycle id_ex_read_data_1=0xAA, id_ex_read_data_2=0x11, id_ex_rd=5, reg_write=1, alu_op=2'b10.
- Bypass and r0: in the same cycle write r7=0x1234_5678 and decode instr reading r7 → read_data returns 0x12345678. A write to r0 of 0xFFFF_FFFF still reads back 0.
- Load-use: lw r2,0(r1) then add r3,r2,r2 → stall=1 for exactly one cycle, one bubble (all control 0) enters ID/EX, then add decodes with rs=rt=2.
- Flush priority: same load-use pair, with flush=1 in the stall cycle → stall=0 and ID/EX holds a bubble.
- Decode values: addi r1,r0,-4 (0x2001FFFC) → id_ex_imm=0xFFFF_FFFC, alu_src=1. Unknown opcode 0x3F → all control 0.
